// File: rtl/baud_pkg.sv
// Shared constants for the baud generator: bus register map and
// parameter legality limits.
package baud_pkg;

    localparam logic [1:0] IOADDR_DIV_LO = 2'b10;
    localparam logic [1:0] IOADDR_DIV_HI = 2'b11;
    localparam logic       IORW_WRITE    = 1'b0;

    localparam int DIV_WIDTH_MIN  = 9;
    localparam int DIV_WIDTH_MAX  = 16;
    localparam int OVERSAMPLE_MIN = 1;
    localparam int OVERSAMPLE_MAX = 256;

    function automatic int os_width(input int os);
        return (os > 1) ? $clog2(os) : 1;
    endfunction

endpackage

// File: rtl/baud_gen_os_if.sv
// I/O bus, receiver resync request and tick outputs of the baud generator.
// master = bus side, slave = generator side.
interface baud_gen_os_if;

    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data;
    logic       sync_rx;
    logic       rxenable;
    logic       txenable;
    logic       running;

    modport master (
        output iocs, iorw, ioaddr, data, sync_rx,
        input  rxenable, txenable, running
    );

    modport slave (
        input  iocs, iorw, ioaddr, data, sync_rx,
        output rxenable, txenable, running
    );

endinterface

// File: rtl/baud_down_counter.sv
// Loadable down counter with zero flag; load wins over decrement.
module baud_down_counter #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= RST_VAL;
        end else if (load) begin
            r_count <= load_val;
        end else if (dec) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule

// File: rtl/baud_gen_os.sv
// Baud-rate generator: divisor-programmed rx oversample tick and tx bit tick,
// atomic two-byte divisor commit, receiver phase resync, idle at divisor 0.
module baud_gen_os
    import baud_pkg::*;
#(
    parameter int DIV_WIDTH   = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 0
) (
    input logic          clk,
    input logic          rst,
    baud_gen_os_if.slave bus
);

    localparam int                   OS_W    = os_width(OVERSAMPLE);
    localparam logic [OS_W-1:0]      OS_TOP  = OS_W'(OVERSAMPLE - 1);
    localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);

    if (DIV_WIDTH < DIV_WIDTH_MIN || DIV_WIDTH > DIV_WIDTH_MAX ||
        OVERSAMPLE < OVERSAMPLE_MIN || OVERSAMPLE > OVERSAMPLE_MAX)
    begin : g_bad_params
        $error("baud_gen_os: DIV_WIDTH or OVERSAMPLE out of range");
    end

    logic [7:0]           r_lo_hold;
    logic [DIV_WIDTH-1:0] r_div;
    logic                 r_rx;
    logic                 r_tx;

    logic                 w_wr;
    logic                 w_wr_lo;
    logic                 w_commit;
    logic                 w_running;
    logic                 w_sync;
    logic                 w_tick;
    logic [DIV_WIDTH-1:0] w_new_div;
    logic [DIV_WIDTH-1:0] w_cnt;
    logic [DIV_WIDTH-1:0] w_cnt_ld_val;
    logic                 w_cnt_zero;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic [OS_W-1:0]      w_os;
    logic                 w_os_zero;
    logic                 w_os_load;
    logic                 w_os_dec;
    logic                 w_unused;

    assign w_wr      = bus.iocs & (bus.iorw == IORW_WRITE);
    assign w_wr_lo   = w_wr & (bus.ioaddr == IOADDR_DIV_LO);
    assign w_commit  = w_wr & (bus.ioaddr == IOADDR_DIV_HI);
    assign w_new_div = {bus.data[DIV_WIDTH-9:0], r_lo_hold};
    assign w_running = |r_div;

    // Commit outranks resync; both restart phase, so neither may tick.
    assign w_sync = w_running & bus.sync_rx & ~w_commit;
    assign w_tick = w_running & w_cnt_zero & ~w_commit & ~bus.sync_rx;

    assign w_cnt_load   = w_commit | w_sync | w_tick;
    assign w_cnt_ld_val = w_commit ? w_new_div : r_div;
    assign w_cnt_dec    = w_running & ~w_cnt_zero;

    assign w_os_load = w_commit | w_sync | (w_tick & w_os_zero);
    assign w_os_dec  = w_tick & ~w_os_zero;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_div     <= DIV_RST;
            r_lo_hold <= '0;
        end else begin
            if (w_commit) r_div <= w_new_div;
            if (w_wr_lo) r_lo_hold <= bus.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx <= 1'b0;
            r_tx <= 1'b0;
        end else begin
            r_rx <= w_tick;
            r_tx <= w_tick & w_os_zero;
        end
    end

    baud_down_counter #(
        .WIDTH   (DIV_WIDTH),
        .RST_VAL (DIV_RST)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_cnt_load),
        .load_val (w_cnt_ld_val),
        .dec      (w_cnt_dec),
        .count    (w_cnt),
        .zero     (w_cnt_zero)
    );

    baud_down_counter #(
        .WIDTH   (OS_W),
        .RST_VAL (OS_TOP)
    ) u_os_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (w_os_load),
        .load_val (OS_TOP),
        .dec      (w_os_dec),
        .count    (w_os),
        .zero     (w_os_zero)
    );

    assign w_unused = ^{w_cnt, w_os};

    assign bus.rxenable = r_rx;
    assign bus.txenable = r_tx;
    assign bus.running  = w_running;

endmodule

// File: tb/tb_baud_gen_os.sv
// Directed bench for baud_gen_os: expected tick cycles are queued when a
// phase-setting event is driven and compared against rx/tx every cycle.
module tb_baud_gen_os;

    typedef struct {
        int   c;
        logic tx;
    } tick_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   cyc;
    int   n_chk;
    int   n_pass;
    bit   mon_a;
    bit   mon_b;
    bit   hit;

    tick_t qa[$];
    tick_t qb[$];

    baud_gen_os_if ifa ();
    baud_gen_os_if ifb ();

    baud_gen_os #(
        .DIV_WIDTH   (12),
        .OVERSAMPLE  (4),
        .DEFAULT_DIV (0)
    ) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa.slave)
    );

    baud_gen_os #(
        .DIV_WIDTH   (16),
        .OVERSAMPLE  (1),
        .DEFAULT_DIV (2)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        tick_t      e;
        logic [1:0] exp;
        @(posedge clk);
        #1;
        cyc++;
        if (mon_a) begin
            exp = 2'b00;
            if (qa.size() > 0 && qa[0].c == cyc) begin
                e   = qa.pop_front();
                exp = {1'b1, e.tx};
            end
            n_chk++;
            assert ({ifa.rxenable, ifa.txenable} === exp) n_pass++;
            else $error("FAIL a_rx_tx cyc=%0d observed=%b expected=%b",
                        cyc, {ifa.rxenable, ifa.txenable}, exp);
        end
        if (mon_b) begin
            exp = 2'b00;
            if (qb.size() > 0 && qb[0].c == cyc) begin
                e   = qb.pop_front();
                exp = {1'b1, e.tx};
            end
            n_chk++;
            assert ({ifb.rxenable, ifb.txenable} === exp) n_pass++;
            else $error("FAIL b_rx_tx cyc=%0d observed=%b expected=%b",
                        cyc, {ifb.rxenable, ifb.txenable}, exp);
        end
    endtask

    task automatic waitn(input int n);
        repeat (n) tick();
    endtask

    task automatic flush_a(input int e);
        while (qa.size() > 0 && qa[qa.size()-1].c >= e) void'(qa.pop_back());
    endtask

    task automatic flush_b(input int e);
        while (qb.size() > 0 && qb[qb.size()-1].c >= e) void'(qb.pop_back());
    endtask

    // Ticks after a phase restart at edge e with divisor d, oversample 4.
    task automatic push_a(input int e, input int d, input int n);
        for (int k = 1; k <= n; k++) qa.push_back('{e + k * (d + 1), (k % 4) == 0});
    endtask

    task automatic push_b(input int e, input int d, input int n);
        for (int k = 1; k <= n; k++) qb.push_back('{e + k * (d + 1), 1'b1});
    endtask

    task automatic wr_a(input logic cs, input logic rw, input logic [1:0] a,
                        input logic [7:0] d, input logic s);
        ifa.iocs    = cs;
        ifa.iorw    = rw;
        ifa.ioaddr  = a;
        ifa.data    = d;
        ifa.sync_rx = s;
        tick();
        ifa.iocs    = 1'b0;
        ifa.iorw    = 1'b1;
        ifa.ioaddr  = 2'b00;
        ifa.data    = 8'h00;
        ifa.sync_rx = 1'b0;
    endtask

    task automatic commit_a(input logic [7:0] hi, input logic s,
                            input int d, input int n);
        flush_a(cyc + 1);
        wr_a(1'b1, 1'b0, 2'b11, hi, s);
        push_a(cyc, d, n);
    endtask

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_pass = 0;
        mon_a  = 0;
        mon_b  = 0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        ifa.iocs = 1'b0; ifa.iorw = 1'b1; ifa.ioaddr = 2'b00;
        ifa.data = 8'h00; ifa.sync_rx = 1'b0;
        ifb.iocs = 1'b0; ifb.iorw = 1'b1; ifb.ioaddr = 2'b00;
        ifb.data = 8'h00; ifb.sync_rx = 1'b0;
        waitn(3);
        mon_a = 1;
        mon_b = 1;
        chk("rst_running_a", ifa.running, 0);
        chk("rst_running_b", ifb.running, 1);

        // Idle after reset with divisor 0
        rst_a = 1'b1;
        repeat (50) begin
            tick();
            chk("idle_running", ifa.running, 0);
        end

        // D=3, oversample 4
        wr_a(1'b1, 1'b0, 2'b10, 8'h03, 1'b0);
        chk("lo_only_running", ifa.running, 0);
        commit_a(8'h00, 1'b0, 3, 64);
        chk("d3_running", ifa.running, 1);
        waitn(40);

        // Staged low byte has no effect until the high write
        wr_a(1'b1, 1'b0, 2'b10, 8'h05, 1'b0);
        waitn(20);
        commit_a(8'h00, 1'b0, 5, 64);
        waitn(40);

        // Resync two clocks after an rx tick
        wr_a(1'b1, 1'b0, 2'b10, 8'h03, 1'b0);
        commit_a(8'h00, 1'b0, 3, 64);
        waitn(10);
        hit = 0;
        for (int i = 0; i < 8 && !hit; i++) begin
            tick();
            hit = (ifa.rxenable === 1'b1);
        end
        chk("sync_find_rx", hit, 1);
        tick();
        flush_a(cyc + 1);
        wr_a(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
        push_a(cyc, 3, 64);
        waitn(40);

        // Commit together with sync_rx acts as the commit
        wr_a(1'b1, 1'b0, 2'b10, 8'h07, 1'b0);
        commit_a(8'h00, 1'b1, 7, 64);
        waitn(70);

        // 12-bit divisor: high byte truncated to its low nibble
        wr_a(1'b1, 1'b0, 2'b10, 8'hFF, 1'b0);
        commit_a(8'hFF, 1'b0, 4095, 3);
        waitn(8200);
        commit_a(8'h00, 1'b0, 255, 64);
        waitn(300);

        // Reads, deselected writes and other addresses change nothing
        wr_a(1'b1, 1'b1, 2'b11, 8'h01, 1'b0);
        wr_a(1'b0, 1'b0, 2'b11, 8'h01, 1'b0);
        wr_a(1'b1, 1'b0, 2'b01, 8'h01, 1'b0);
        wr_a(1'b1, 1'b0, 2'b00, 8'h01, 1'b0);
        wr_a(1'b1, 1'b1, 2'b10, 8'h01, 1'b0);
        waitn(300);
        commit_a(8'h00, 1'b0, 255, 64);
        waitn(600);

        // Reset mid-count discards divisor and staged low byte
        wr_a(1'b1, 1'b0, 2'b10, 8'h03, 1'b0);
        commit_a(8'h00, 1'b0, 3, 64);
        waitn(9);
        flush_a(cyc + 1);
        rst_a = 1'b0;
        tick();
        rst_a = 1'b1;
        chk("post_rst_running", ifa.running, 0);
        waitn(30);
        wr_a(1'b0, 1'b0, 2'b00, 8'h00, 1'b1);
        waitn(20);
        commit_a(8'h00, 1'b0, 0, 0);
        chk("lo_cleared_running", ifa.running, 0);
        waitn(20);
        wr_a(1'b1, 1'b0, 2'b10, 8'h02, 1'b0);
        commit_a(8'h00, 1'b0, 2, 64);
        chk("reprog_running", ifa.running, 1);
        waitn(30);
        wr_a(1'b1, 1'b0, 2'b10, 8'h00, 1'b0);
        commit_a(8'h00, 1'b0, 0, 0);
        chk("stop_running", ifa.running, 0);
        waitn(20);

        // DEFAULT_DIV=2, OVERSAMPLE=1: ticks straight out of reset
        push_b(cyc, 2, 64);
        rst_b = 1'b1;
        waitn(30);
        chk("b_running", ifb.running, 1);
        flush_b(cyc + 1);
        rst_b = 1'b0;
        tick();
        push_b(cyc, 2, 64);
        rst_b = 1'b1;
        waitn(30);

        mon_a = 0;
        mon_b = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
